// File: rtl/agendador_tiros_inimigos.sv
// Enemy shot scheduler: cooldown pacing, round-robin shooter choice and bullet slot ownership.
// Optional build macro TIRO_JITTER_EN adds an LFSR jitter to the cooldown terminal count.
module agendador_tiros_inimigos #(
  parameter int unsigned N_INIMIGOS = 4,
  parameter int unsigned N_SLOTS    = 2,
  parameter int unsigned COOLDOWN   = 50000000,
  parameter int unsigned OFFSET_Y   = 16,
  parameter int unsigned Y_MAX      = 539
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_INIMIGOS-1:0]   inimigo_vivo,
  input  logic [11*N_INIMIGOS-1:0] posX_inimigos,
  input  logic [11*N_INIMIGOS-1:0] posY_inimigos,
  input  logic [N_SLOTS-1:0]      slot_fim,
  output logic [N_SLOTS-1:0]      lanca,
  output logic [10:0]             lancaX,
  output logic [10:0]             lancaY,
  output logic [N_SLOTS-1:0]      slot_ocupado,
  output logic [2:0]              atirador
);

  localparam int unsigned CntW = $clog2(COOLDOWN + 256);
  localparam logic [N_SLOTS-1:0] SlotUm = 1;

  typedef enum logic [1:0] {StEspera, StEscolhe, StLanca} estado_e;

  estado_e             estado_q, estado_d;
  logic [CntW-1:0]     cnt_q, cnt_d, terminal;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          shooter_q, shooter_d;
  logic [2:0]          atirador_q, atirador_d;
  logic [N_SLOTS-1:0]  lanca_q, lanca_d;
  logic [N_SLOTS-1:0]  ocupado_q, ocupado_d;
  logic [10:0]         lanca_x_q, lanca_x_d;
  logic [10:0]         lanca_y_q, lanca_y_d;

  logic [7:0]          vivo_ext;
  logic [87:0]         pos_x_ext, pos_y_ext;
  logic [10:0]         pos_x_arr [8];
  logic [10:0]         pos_y_arr [8];
  logic                achou;
  logic [2:0]          cand, escolhido;
  logic [N_SLOTS-1:0]  slot_sel;
  logic                slot_livre;
  logic [11:0]         soma_y;

`ifdef TIRO_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign terminal = CntW'(COOLDOWN - 1) + CntW'(lfsr_q);
`else
  assign terminal = CntW'(COOLDOWN - 1);
`endif

  // Pad the packed buses to 8 entries so 3-bit indices never run off the end.
  assign vivo_ext  = 8'(inimigo_vivo);
  assign pos_x_ext = 88'(posX_inimigos);
  assign pos_y_ext = 88'(posY_inimigos);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pos_x_arr[i] = pos_x_ext[11*i +: 11];
      pos_y_arr[i] = pos_y_ext[11*i +: 11];
    end
  end

  // First alive enemy scanning upward from the round-robin pointer.
  always_comb begin
    achou     = 1'b0;
    escolhido = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_INIMIGOS; k++) begin
      cand = 3'((32'(ptr_q) + k) % N_INIMIGOS);
      if (!achou && vivo_ext[cand]) begin
        achou     = 1'b1;
        escolhido = cand;
      end
    end
  end

  always_comb begin
    slot_sel = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!ocupado_q[i]) slot_sel = SlotUm << i;
    end
  end

  assign slot_livre = ~&ocupado_q;
  assign soma_y     = {1'b0, pos_y_arr[escolhido]} + 12'(OFFSET_Y);

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    shooter_d  = shooter_q;
    atirador_d = atirador_q;
    lanca_d    = '0;
    lanca_x_d  = lanca_x_q;
    lanca_y_d  = lanca_y_q;
    // A launch on the same edge as slot_fim overrides the release below.
    ocupado_d  = ocupado_q & ~slot_fim;
`ifdef TIRO_JITTER_EN
    lfsr_d     = lfsr_q;
`endif
    unique case (estado_q)
      StEspera: begin
        if (enable) begin
          if (cnt_q >= terminal) begin
            cnt_d    = '0;
            estado_d = StEscolhe;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StEscolhe: begin
        if (!enable || !achou) begin
          cnt_d    = '0;
          estado_d = StEspera;
        end else if (slot_livre) begin
          lanca_d   = slot_sel;
          shooter_d = escolhido;
          lanca_x_d = pos_x_arr[escolhido];
          lanca_y_d = (soma_y > 12'(Y_MAX)) ? 11'(Y_MAX) : soma_y[10:0];
          estado_d  = StLanca;
        end
      end
      StLanca: begin
        ocupado_d  = ocupado_d | lanca_q;
        atirador_d = shooter_q;
        ptr_d      = 3'((32'(shooter_q) + 1) % N_INIMIGOS);
        estado_d   = StEspera;
`ifdef TIRO_JITTER_EN
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
      end
      default: estado_d = StEspera;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= StEspera;
      cnt_q      <= '0;
      ptr_q      <= '0;
      shooter_q  <= '0;
      atirador_q <= '0;
      lanca_q    <= '0;
      ocupado_q  <= '0;
      lanca_x_q  <= '0;
      lanca_y_q  <= '0;
`ifdef TIRO_JITTER_EN
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      shooter_q  <= shooter_d;
      atirador_q <= atirador_d;
      lanca_q    <= lanca_d;
      ocupado_q  <= ocupado_d;
      lanca_x_q  <= lanca_x_d;
      lanca_y_q  <= lanca_y_d;
`ifdef TIRO_JITTER_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign lanca        = lanca_q;
  assign lancaX       = lanca_x_q;
  assign lancaY       = lanca_y_q;
  assign slot_ocupado = ocupado_q;
  assign atirador     = atirador_q;

endmodule

// File: tb/tb_agendador_tiros_inimigos.sv
// Self-checking bench for agendador_tiros_inimigos: scenario tasks against a behavioural model.
module tb_agendador_tiros_inimigos;

  localparam int N    = 4;
  localparam int CD   = 10;
  localparam int OFFY = 16;
  localparam int YMAX = 539;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  vivo;
  logic [43:0] posx, posy;
  logic [1:0]  slot_fim;
  logic [1:0]  lanca;
  logic [10:0] lancaX, lancaY;
  logic [1:0]  slot_ocupado;
  logic [2:0]  atirador;

  logic [10:0] px [N];
  logic [10:0] py [N];

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m;
  logic [1:0] busy_m;

  agendador_tiros_inimigos #(
    .N_INIMIGOS(N), .N_SLOTS(2), .COOLDOWN(CD), .OFFSET_Y(OFFY), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .inimigo_vivo(vivo),
    .posX_inimigos(posx), .posY_inimigos(posy), .slot_fim(slot_fim),
    .lanca(lanca), .lancaX(lancaX), .lancaY(lancaY),
    .slot_ocupado(slot_ocupado), .atirador(atirador)
  );

  always #5 clk = ~clk;

  always_comb begin
    posx = '0;
    posy = '0;
    for (int i = 0; i < N; i++) begin
      posx[11*i +: 11] = px[i];
      posy[11*i +: 11] = py[i];
    end
  end

  function automatic int exp_shooter(int ptr, logic [3:0] alive);
    for (int k = 0; k < N; k++) if (alive[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int exp_y(int y);
    int s;
    s = y + OFFY;
    return (s > YMAX) ? YMAX : s;
  endfunction

  function automatic logic [1:0] exp_slot(logic [1:0] busy);
    if (!busy[0]) return 2'b01;
    if (!busy[1]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_pos();
    for (int i = 0; i < N; i++) begin
      px[i] = 11'($urandom_range(0, 799));
      py[i] = 11'($urandom_range(0, 2047));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; slot_fim = '0;
    tick(); tick();
    reset = 1'b0;
    ptr_m = 0; busy_m = '0;
  endtask

  task automatic wait_launch(input int budget, output int n, output logic [1:0] seen);
    n = 0; seen = '0;
    while (n < budget && seen == 2'b00) begin
      tick(); n++; seen = lanca;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; slot_fim = '0; vivo = 4'hF; randomize_pos();
    tick();
    n_checks++; if (lanca !== 2'b00) begin n_fail++; $display("FAIL reset_lanca: got %b expected 00", lanca); end
    n_checks++; if (lancaX !== 11'd0) begin n_fail++; $display("FAIL reset_lancaX: got %0d expected 0", lancaX); end
    n_checks++; if (lancaY !== 11'd0) begin n_fail++; $display("FAIL reset_lancaY: got %0d expected 0", lancaY); end
    n_checks++; if (slot_ocupado !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b expected 00", slot_ocupado); end
    n_checks++; if (atirador !== 3'd0) begin n_fail++; $display("FAIL reset_atirador: got %0d expected 0", atirador); end
  endtask

  task automatic test_first_shot();
    do_reset();
    vivo = 4'hF; randomize_pos(); px[0] = 11'd100; py[0] = 11'd50;
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks++;
      if (lanca !== ((c == CD + 1) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL first_shot_lanca cycle %0d: got %b", c, lanca);
      end
      if (c == CD + 1) begin
        n_checks++; if (lancaX !== 11'd100) begin n_fail++; $display("FAIL first_shot_x: got %0d expected 100", lancaX); end
        n_checks++; if (lancaY !== 11'd66) begin n_fail++; $display("FAIL first_shot_y: got %0d expected 66", lancaY); end
      end
      if (c == CD + 2) begin
        n_checks++; if (atirador !== 3'd0) begin n_fail++; $display("FAIL first_shot_atirador: got %0d expected 0", atirador); end
        n_checks++; if (slot_ocupado !== 2'b01) begin n_fail++; $display("FAIL first_shot_busy: got %b expected 01", slot_ocupado); end
      end
    end
  endtask

  task automatic test_round_robin();
    int n, s;
    logic [1:0] seen;
    do_reset();
    vivo = 4'hF; randomize_pos(); enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s = exp_shooter(ptr_m, vivo);
      wait_launch(40, n, seen);
      n_checks++; if (n != ((k == 0) ? CD + 1 : CD - 2)) begin n_fail++; $display("FAIL rr_latency %0d: got %0d cycles", k, n); end
      n_checks++; if (seen !== 2'b01) begin n_fail++; $display("FAIL rr_slot %0d: got %b expected 01", k, seen); end
      n_checks++; if (int'(lancaX) != int'(px[s])) begin n_fail++; $display("FAIL rr_x %0d: got %0d expected %0d", k, lancaX, px[s]); end
      n_checks++; if (int'(lancaY) != exp_y(int'(py[s]))) begin n_fail++; $display("FAIL rr_y %0d: got %0d expected %0d", k, lancaY, exp_y(int'(py[s]))); end
      tick();
      n_checks++; if (int'(atirador) != s) begin n_fail++; $display("FAIL rr_atirador %0d: got %0d expected %0d", k, atirador, s); end
      ptr_m = (s + 1) % N;
      tick(); tick();
      slot_fim = 2'b01;
      tick();
      slot_fim = 2'b00;
      n_checks++; if (slot_ocupado !== 2'b00) begin n_fail++; $display("FAIL rr_release %0d: got %b expected 00", k, slot_ocupado); end
    end
  endtask

  task automatic test_starvation();
    int n;
    logic [1:0] seen;
    do_reset();
    vivo = 4'hF; randomize_pos(); enable = 1'b1;
    wait_launch(40, n, seen);
    n_checks++; if (seen !== 2'b01) begin n_fail++; $display("FAIL starve_first: got %b expected 01", seen); end
    wait_launch(40, n, seen);
    n_checks++; if (seen !== 2'b10 || n != CD + 2) begin n_fail++; $display("FAIL starve_second: got %b after %0d expected 10 after %0d", seen, n, CD + 2); end
    wait_launch(20, n, seen);
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL starve_hold: got %b expected 00", seen); end
    n_checks++; if (slot_ocupado !== 2'b11) begin n_fail++; $display("FAIL starve_busy: got %b expected 11", slot_ocupado); end
    slot_fim = 2'b10;
    tick();
    slot_fim = 2'b00;
    n_checks++; if (slot_ocupado !== 2'b01) begin n_fail++; $display("FAIL starve_freed: got %b expected 01", slot_ocupado); end
    n_checks++; if (lanca !== 2'b00) begin n_fail++; $display("FAIL starve_early: got %b expected 00", lanca); end
    tick();
    n_checks++; if (lanca !== 2'b10) begin n_fail++; $display("FAIL starve_launch: got %b expected 10", lanca); end
    n_checks++; if (int'(lancaY) != exp_y(int'(py[2]))) begin n_fail++; $display("FAIL starve_y: got %0d expected %0d", lancaY, exp_y(int'(py[2]))); end
    tick();
    n_checks++; if (slot_ocupado !== 2'b11) begin n_fail++; $display("FAIL starve_rebusy: got %b expected 11", slot_ocupado); end
    n_checks++; if (atirador !== 3'd2) begin n_fail++; $display("FAIL starve_atirador: got %0d expected 2", atirador); end
  endtask

  task automatic test_alive_mask();
    int n;
    logic [1:0] seen;
    do_reset();
    vivo = 4'b0100; randomize_pos(); enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_launch(40, n, seen);
      n_checks++; if (seen !== 2'b01) begin n_fail++; $display("FAIL mask_slot %0d: got %b expected 01", k, seen); end
      n_checks++; if (lancaX !== px[2]) begin n_fail++; $display("FAIL mask_x %0d: got %0d expected %0d", k, lancaX, px[2]); end
      tick();
      n_checks++; if (atirador !== 3'd2) begin n_fail++; $display("FAIL mask_atirador %0d: got %0d expected 2", k, atirador); end
      tick(); tick();
      slot_fim = 2'b01;
      tick();
      slot_fim = 2'b00;
    end
    vivo = 4'b0000;
    wait_launch(CD - 2, n, seen);
    n_checks++; if (seen !== 2'b00) begin n_fail++; $display("FAIL mask_none: got %b expected 00", seen); end
    vivo = 4'b0100;
    wait_launch(30, n, seen);
    n_checks++; if (n != CD + 1 || seen !== 2'b01) begin n_fail++; $display("FAIL mask_restart: got %b after %0d expected 01 after %0d", seen, n, CD + 1); end
  endtask

  task automatic test_clamp();
    int n;
    logic [1:0] seen;
    do_reset();
    vivo = 4'hF; randomize_pos();
    py[0] = 11'd530; py[1] = 11'd2047; py[2] = 11'd522;
    enable = 1'b1;
    wait_launch(40, n, seen);
    n_checks++; if (lancaY !== 11'd539) begin n_fail++; $display("FAIL clamp_530: got %0d expected 539", lancaY); end
    n_checks++; if (lancaX !== px[0]) begin n_fail++; $display("FAIL clamp_x: got %0d expected %0d", lancaX, px[0]); end
    wait_launch(40, n, seen);
    n_checks++; if (lancaY !== 11'd539) begin n_fail++; $display("FAIL clamp_2047: got %0d expected 539", lancaY); end
    tick(); tick();
    slot_fim = 2'b01;
    tick();
    slot_fim = 2'b00;
    wait_launch(40, n, seen);
    n_checks++; if (lancaY !== 11'd538 || seen !== 2'b01) begin n_fail++; $display("FAIL clamp_522: got %0d slot %b expected 538 slot 01", lancaY, seen); end
  endtask

  task automatic test_random();
    int n, s;
    logic [1:0] seen, es, fim;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vivo = 4'($urandom_range(1, 15));
      randomize_pos();
      s  = exp_shooter(ptr_m, vivo);
      es = exp_slot(busy_m);
      wait_launch(40, n, seen);
      n_checks++; if (n != ((k == 0) ? CD + 1 : CD - 1)) begin n_fail++; $display("FAIL rand_latency %0d: got %0d cycles", k, n); end
      n_checks++; if (seen !== es) begin n_fail++; $display("FAIL rand_slot %0d: got %b expected %b", k, seen, es); end
      n_checks++; if (int'(lancaX) != int'(px[s])) begin n_fail++; $display("FAIL rand_x %0d: got %0d expected %0d", k, lancaX, px[s]); end
      n_checks++; if (int'(lancaY) != exp_y(int'(py[s]))) begin n_fail++; $display("FAIL rand_y %0d: got %0d expected %0d", k, lancaY, exp_y(int'(py[s]))); end
      tick();
      busy_m = busy_m | es;
      ptr_m = (s + 1) % N;
      n_checks++; if (int'(atirador) != s) begin n_fail++; $display("FAIL rand_atirador %0d: got %0d expected %0d", k, atirador, s); end
      n_checks++; if (slot_ocupado !== busy_m) begin n_fail++; $display("FAIL rand_busy %0d: got %b expected %b", k, slot_ocupado, busy_m); end
      tick();
      fim = (busy_m == 2'b11) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 3));
      slot_fim = fim;
      tick();
      slot_fim = 2'b00;
      busy_m = busy_m & ~fim;
      n_checks++; if (slot_ocupado !== busy_m) begin n_fail++; $display("FAIL rand_release %0d: got %b expected %b", k, slot_ocupado, busy_m); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [1:0] seen;
    do_reset();
    vivo = 4'hF; randomize_pos(); enable = 1'b1;
    wait_launch(40, n, seen);
    wait_launch(40, n, seen);
    n_checks++; if (seen !== 2'b10) begin n_fail++; $display("FAIL midrst_setup: got %b expected 10", seen); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (lanca !== 2'b00) begin n_fail++; $display("FAIL midrst_lanca: got %b expected 00", lanca); end
    n_checks++; if (slot_ocupado !== 2'b00) begin n_fail++; $display("FAIL midrst_busy: got %b expected 00", slot_ocupado); end
    n_checks++; if (lancaX !== 11'd0) begin n_fail++; $display("FAIL midrst_x: got %0d expected 0", lancaX); end
    tick(); tick();
    reset = 1'b0;
    wait_launch(40, n, seen);
    n_checks++; if (n != CD + 1 || seen !== 2'b01) begin n_fail++; $display("FAIL midrst_relaunch: got %b after %0d expected 01 after %0d", seen, n, CD + 1); end
    tick();
    n_checks++; if (atirador !== 3'd0) begin n_fail++; $display("FAIL midrst_atirador: got %0d expected 0", atirador); end
  endtask

  initial begin
    test_reset();
    test_first_shot();
    test_round_robin();
    test_starvation();
    test_alive_mask();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
